// File: rtl/johnson_pkg.sv
// ---------------------------------------------------------------------------
// johnson_pkg
// Shared constants and helpers for the parametrised Johnson / ring counter.
//   MODE_JOHNSON / MODE_RING : values of the run-time mode input
//   DIR_FWD / DIR_REV        : values of the direction input
//   idx_width(n)             : width of the decoded phase index for width n
// ---------------------------------------------------------------------------
package johnson_pkg;

  localparam logic MODE_JOHNSON = 1'b0;
  localparam logic MODE_RING    = 1'b1;
  localparam logic DIR_FWD      = 1'b0;
  localparam logic DIR_REV      = 1'b1;

  // Johnson mode has 2n phases, so the index needs clog2(2n) bits.
  function automatic int idx_width(input int n);
    return $clog2(2 * n);
  endfunction

endpackage

// File: rtl/johnson_counter_gen_if.sv
// ---------------------------------------------------------------------------
// johnson_counter_gen_if
// Control/status bundle of the Johnson / ring counter.
//   master : drives en, dir, mode, load, ld_val, clr_err; observes status
//   slave  : the counter; observes controls, drives out, idx, legal, wrap, err
// ---------------------------------------------------------------------------
interface johnson_counter_gen_if
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
);

  logic          en;
  logic          dir;
  logic          mode;
  logic          load;
  logic [N-1:0]  ld_val;
  logic          clr_err;
  logic [N-1:0]  out;
  logic [IW-1:0] idx;
  logic          legal;
  logic          wrap;
  logic          err;

  modport master (
    output en, dir, mode, load, ld_val, clr_err,
    input  out, idx, legal, wrap, err
  );

  modport slave (
    input  en, dir, mode, load, ld_val, clr_err,
    output out, idx, legal, wrap, err
  );

endinterface

// File: rtl/shift_state_decode.sv
// ---------------------------------------------------------------------------
// shift_state_decode
// Purely combinational classifier of a shift-register counter state.
//   state : counter value
//   mode  : MODE_JOHNSON or MODE_RING
//   legal : state belongs to the sequence of the given mode
//   idx   : phase index of state within that sequence, 0 when illegal
// ---------------------------------------------------------------------------
module shift_state_decode
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  state,
  input  logic          mode,
  output logic          legal,
  output logic [IW-1:0] idx
);

  int pop_cnt;
  int trans_cnt;
  int set_pos;
  int idx_int;

  always_comb begin
    pop_cnt   = 0;
    trans_cnt = 0;
    set_pos   = 0;
    idx_int   = 0;
    legal     = 1'b0;

    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + int'(state[i]);
      if (state[i]) set_pos = i;
    end
    for (int i = 0; i < N - 1; i++) begin
      trans_cnt = trans_cnt + int'(state[i] != state[i+1]);
    end

    if (mode == MODE_JOHNSON) begin
      // A twisted-ring state is one contiguous run of ones; the fill phase
      // (bit 0 still clear) counts up, the drain phase counts on to 2N-1.
      legal   = (trans_cnt <= 1);
      idx_int = state[0] ? (2 * N - pop_cnt) : pop_cnt;
    end else begin
      // Forward rotation moves the bit downward from bit 0 to bit N-1.
      legal   = (pop_cnt == 1);
      idx_int = (set_pos == 0) ? 0 : (N - set_pos);
    end

    idx = legal ? IW'(idx_int) : '0;
  end

endmodule

// File: rtl/johnson_counter_gen.sv
// ---------------------------------------------------------------------------
// johnson_counter_gen
// Parametrised shift-register phase generator with Johnson (2N states) and
// ring (N states) modes, up/down stepping, parallel load and self-correction
// of illegal states.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : johnson_counter_gen_if.slave
//          in  en, dir, mode, load, ld_val, clr_err
//          out out (registered), idx / legal (combinational from out),
//              wrap (registered one-cycle pulse), err (sticky)
// ---------------------------------------------------------------------------
module johnson_counter_gen
  import johnson_pkg::*;
#(
  parameter int           N       = 4,
  parameter logic [N-1:0] RST_VAL = {{(N-1){1'b0}}, 1'b1},
  parameter int           IW      = idx_width(N)
) (
  input logic                  clk,
  input logic                  rstn,
  johnson_counter_gen_if.slave bus
);

  logic [N-1:0]  cnt_q, cnt_nxt;
  logic [N-1:0]  step_val;
  logic          wrap_q, wrap_nxt;
  logic          err_q, err_nxt;
  logic          legal;
  logic [IW-1:0] idx;
  logic [IW-1:0] last_idx;

  shift_state_decode #(
    .N  (N),
    .IW (IW)
  ) u_decode (
    .state (cnt_q),
    .mode  (bus.mode),
    .legal (legal),
    .idx   (idx)
  );

  assign last_idx = (bus.mode == MODE_JOHNSON) ? IW'(2 * N - 1) : IW'(N - 1);

  always_comb begin
    step_val = cnt_q;
    case ({bus.mode, bus.dir})
      {MODE_JOHNSON, DIR_FWD}: step_val = {~cnt_q[0], cnt_q[N-1:1]};
      {MODE_JOHNSON, DIR_REV}: step_val = {cnt_q[N-2:0], ~cnt_q[N-1]};
      {MODE_RING,    DIR_FWD}: step_val = {cnt_q[0], cnt_q[N-1:1]};
      {MODE_RING,    DIR_REV}: step_val = {cnt_q[N-2:0], cnt_q[N-1]};
      default:                 step_val = cnt_q;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt_q;
    wrap_nxt = 1'b0;
    // A correction on the same edge as clr_err re-sets err below.
    err_nxt  = err_q & ~bus.clr_err;

    if (bus.load) begin
      cnt_nxt = bus.ld_val;
    end else if (bus.en) begin
      if (!legal) begin
        cnt_nxt = RST_VAL;
        err_nxt = 1'b1;
      end else begin
        cnt_nxt  = step_val;
        wrap_nxt = (bus.dir == DIR_FWD) ? (idx == last_idx) : (idx == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= RST_VAL;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      wrap_q <= wrap_nxt;
      err_q  <= err_nxt;
    end
  end

  assign bus.out   = cnt_q;
  assign bus.idx   = idx;
  assign bus.legal = legal;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_johnson_counter_gen.sv
module tb_johnson_counter_gen;

  typedef struct {
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] ld_val;
    logic       clr_err;
    logic [3:0] e_out;
    logic [2:0] e_idx;
    logic       e_legal;
    logic       e_wrap;
    logic       e_err;
  } vec_t;

  logic clk;
  logic rstn;
  logic rstn7;
  int   n_tests;
  int   n_fail;
  vec_t vq[$];

  johnson_counter_gen_if #(.N(4)) bus4 ();
  johnson_counter_gen_if #(.N(7)) bus7 ();

  johnson_counter_gen #(.N(4)) dut4 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus4)
  );

  johnson_counter_gen #(.N(7)) dut7 (
    .clk  (clk),
    .rstn (rstn7),
    .bus  (bus7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic dir, input logic mode,
                              input logic load, input logic [3:0] ld_val,
                              input logic clr_err, input logic [3:0] e_out,
                              input logic [2:0] e_idx, input logic e_legal,
                              input logic e_wrap, input logic e_err);
    vec_t v;
    v.en = en; v.dir = dir; v.mode = mode; v.load = load; v.ld_val = ld_val;
    v.clr_err = clr_err; v.e_out = e_out; v.e_idx = e_idx;
    v.e_legal = e_legal; v.e_wrap = e_wrap; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic en, input logic dir, input logic mode,
                        input logic load, input logic [3:0] ld_val, input logic clr_err);
    bus4.en = en; bus4.dir = dir; bus4.mode = mode;
    bus4.load = load; bus4.ld_val = ld_val; bus4.clr_err = clr_err;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    rstn7   = 1'b0;
    drive4(0, 0, 0, 0, 4'b0000, 0);
    bus7.en = 1'b0; bus7.dir = 1'b0; bus7.mode = 1'b0;
    bus7.load = 1'b0; bus7.ld_val = '0; bus7.clr_err = 1'b0;

    // Johnson forward
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b0000,3'd0,1,1,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b1000,3'd1,1,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b1100,3'd2,1,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b1110,3'd3,1,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b1111,3'd4,1,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b0111,3'd5,1,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b0011,3'd6,1,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b0001,3'd7,1,0,0));
    // Johnson reverse
    vq.push_back(mk(1,1,0,0,4'b0000,0, 4'b0011,3'd6,1,0,0));
    vq.push_back(mk(1,1,0,0,4'b0000,0, 4'b0111,3'd5,1,0,0));
    vq.push_back(mk(1,1,0,0,4'b0000,0, 4'b1111,3'd4,1,0,0));
    vq.push_back(mk(1,1,0,0,4'b0000,0, 4'b1110,3'd3,1,0,0));
    vq.push_back(mk(1,1,0,0,4'b0000,0, 4'b1100,3'd2,1,0,0));
    vq.push_back(mk(1,1,0,0,4'b0000,0, 4'b1000,3'd1,1,0,0));
    vq.push_back(mk(1,1,0,0,4'b0000,0, 4'b0000,3'd0,1,0,0));
    vq.push_back(mk(1,1,0,0,4'b0000,0, 4'b0001,3'd7,1,1,0));
    // Ring forward
    vq.push_back(mk(1,0,1,0,4'b0000,0, 4'b1000,3'd1,1,0,0));
    vq.push_back(mk(1,0,1,0,4'b0000,0, 4'b0100,3'd2,1,0,0));
    vq.push_back(mk(1,0,1,0,4'b0000,0, 4'b0010,3'd3,1,0,0));
    vq.push_back(mk(1,0,1,0,4'b0000,0, 4'b0001,3'd0,1,1,0));
    // Ring reverse
    vq.push_back(mk(1,1,1,0,4'b0000,0, 4'b0010,3'd3,1,1,0));
    vq.push_back(mk(1,1,1,0,4'b0000,0, 4'b0100,3'd2,1,0,0));
    vq.push_back(mk(1,1,1,0,4'b0000,0, 4'b1000,3'd1,1,0,0));
    vq.push_back(mk(1,1,1,0,4'b0000,0, 4'b0001,3'd0,1,0,0));
    // Illegal load, hold, correction, clear
    vq.push_back(mk(0,0,0,1,4'b0110,0, 4'b0110,3'd0,0,0,0));
    vq.push_back(mk(0,0,0,0,4'b0000,0, 4'b0110,3'd0,0,0,0));
    vq.push_back(mk(0,0,0,0,4'b0000,0, 4'b0110,3'd0,0,0,0));
    vq.push_back(mk(0,0,0,0,4'b0000,0, 4'b0110,3'd0,0,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b0001,3'd7,1,0,1));
    vq.push_back(mk(0,0,0,0,4'b0000,1, 4'b0001,3'd7,1,0,0));
    // Load beats correction on an illegal state
    vq.push_back(mk(0,0,0,1,4'b0110,0, 4'b0110,3'd0,0,0,0));
    vq.push_back(mk(1,0,0,1,4'b1000,0, 4'b1000,3'd1,1,0,0));
    // Ring 1000 -> Johnson: legal there, sequence continues
    vq.push_back(mk(0,0,1,1,4'b1000,0, 4'b1000,3'd1,1,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b1100,3'd2,1,0,0));
    // Ring 0100 -> Johnson: illegal there, corrected
    vq.push_back(mk(0,0,1,1,4'b0100,0, 4'b0100,3'd2,1,0,0));
    vq.push_back(mk(1,0,0,0,4'b0000,0, 4'b0001,3'd7,1,0,1));
    // Set and clear of err on the same edge: set wins
    vq.push_back(mk(0,0,1,1,4'b0011,0, 4'b0011,3'd0,0,0,1));
    vq.push_back(mk(1,0,1,0,4'b0000,1, 4'b0001,3'd0,1,0,1));
    vq.push_back(mk(0,0,1,0,4'b0000,1, 4'b0001,3'd0,1,0,0));

    // Reset state
    #12;
    check("reset out", 32'(bus4.out), 32'h1);
    check("reset idx", 32'(bus4.idx), 32'd7);
    check("reset wrap", 32'(bus4.wrap), 32'd0);
    check("reset err", 32'(bus4.err), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (vq[i]) begin
      drive4(vq[i].en, vq[i].dir, vq[i].mode, vq[i].load, vq[i].ld_val, vq[i].clr_err);
      tick();
      check($sformatf("row%0d out", i),   32'(bus4.out),   32'(vq[i].e_out));
      check($sformatf("row%0d idx", i),   32'(bus4.idx),   32'(vq[i].e_idx));
      check($sformatf("row%0d legal", i), 32'(bus4.legal), 32'(vq[i].e_legal));
      check($sformatf("row%0d wrap", i),  32'(bus4.wrap),  32'(vq[i].e_wrap));
      check($sformatf("row%0d err", i),   32'(bus4.err),   32'(vq[i].e_err));
    end

    // Mode switch seen combinationally before the edge
    drive4(0, 0, 1, 1, 4'b0100, 0);
    tick();
    drive4(0, 0, 0, 0, 4'b0000, 0);
    #1;
    check("modesw legal", 32'(bus4.legal), 32'd0);
    check("modesw idx", 32'(bus4.idx), 32'd0);

    // Asynchronous reset between edges with wrap and err both high
    drive4(1, 0, 0, 0, 4'b0000, 0);
    tick();
    check("pre-rst err", 32'(bus4.err), 32'd1);
    tick();
    check("pre-rst out", 32'(bus4.out), 32'h0);
    check("pre-rst wrap", 32'(bus4.wrap), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async rst out", 32'(bus4.out), 32'h1);
    check("async rst wrap", 32'(bus4.wrap), 32'd0);
    check("async rst err", 32'(bus4.err), 32'd0);
    tick();
    check("held rst out", 32'(bus4.out), 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("post-rst out", 32'(bus4.out), 32'h0);
    check("post-rst wrap", 32'(bus4.wrap), 32'd1);

    // N=7: full 14-state Johnson cycle
    drive4(0, 0, 0, 0, 4'b0000, 0);
    #1;
    check("n7 reset out", 32'(bus7.out), 32'h01);
    check("n7 reset idx", 32'(bus7.idx), 32'd13);
    @(negedge clk);
    rstn7   = 1'b1;
    bus7.en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("n7 step%0d idx", k), 32'(bus7.idx), 32'((k - 1) % 14));
      check($sformatf("n7 step%0d legal", k), 32'(bus7.legal), 32'd1);
      check($sformatf("n7 step%0d wrap", k), 32'(bus7.wrap), 32'((k == 1) || (k == 15)));
      if (k == 8)  check("n7 step8 out", 32'(bus7.out), 32'h7F);
      if (k == 14) check("n7 step14 out", 32'(bus7.out), 32'h01);
    end
    bus7.en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
